// File: rtl/credit_sender.sv
// Credit-based link transmitter: forwards producer words through a registered ready-less
// valid/bits link, never exceeding the remote queue's free entries. Optional macro:
// CREDIT_SENDER_RETURN_BYPASS_EN lets a same-cycle credit return enable acceptance at zero credits.
module credit_sender #(
    parameter  int WIDTH   = 8,
    parameter  int CREDITS = 2,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             io_in_ready,
    input  logic             io_in_valid,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_out_valid,
    output logic [WIDTH-1:0] io_out_bits,
    input  logic             io_credit_return,
    output logic [CNT_W-1:0] io_credits,
    output logic             io_err
);

    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] credits_q, credits_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_bits_q, out_bits_d;
    logic             err_q, err_d;
    logic             in_ready;
    logic             fire;

`ifdef CREDIT_SENDER_RETURN_BYPASS_EN
    // A credit arriving while empty is spent in the same cycle; the count stays at zero.
    assign in_ready = (credits_q != '0) || io_credit_return;
`else
    assign in_ready = (credits_q != '0);
`endif

    assign fire = io_in_valid && in_ready;

    always_comb begin
        credits_d   = credits_q;
        err_d       = err_q;
        out_valid_d = fire;
        out_bits_d  = out_bits_q;
        if (fire) begin
            out_bits_d = io_in_bits;
        end
        if (fire && !io_credit_return) begin
            credits_d = credits_q - CNT_ONE;
        end else if (!fire && io_credit_return) begin
            // A return with every credit already home means the remote side is confused.
            if (credits_q == CREDITS_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q   <= CREDITS_MAX;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            err_q       <= err_d;
        end
    end

    assign io_in_ready  = in_ready;
    assign io_out_valid = out_valid_q;
    assign io_out_bits  = out_bits_q;
    assign io_credits   = credits_q;
    assign io_err       = err_q;

endmodule

// File: tb/tb_credit_sender.sv
// Scoreboard bench for credit_sender (WIDTH=8, CREDITS=2): expected words are queued when
// acceptance is predicted and popped when the output register presents a word.
module tb_credit_sender;

    localparam int WIDTH   = 8;
    localparam int CREDITS = 2;
    localparam int CNT_W   = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             io_in_ready;
    logic             io_in_valid;
    logic [WIDTH-1:0] io_in_bits;
    logic             io_out_valid;
    logic [WIDTH-1:0] io_out_bits;
    logic             io_credit_return;
    logic [CNT_W-1:0] io_credits;
    logic             io_err;

    int vectors = 0;
    int errors  = 0;
    logic [WIDTH-1:0] exp_q[$];

    credit_sender #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_in_ready      (io_in_ready),
        .io_in_valid      (io_in_valid),
        .io_in_bits       (io_in_bits),
        .io_out_valid     (io_out_valid),
        .io_out_bits      (io_out_bits),
        .io_credit_return (io_credit_return),
        .io_credits       (io_credits),
        .io_err           (io_err)
    );

    always #5 clk = ~clk;

    // Output monitor: every presented word must match the oldest expected one.
    always @(negedge clk) begin
        if (io_out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h, none required", io_out_bits);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (io_out_bits !== e) begin
                    errors++;
                    $display("FAIL out_bits: got %h required %h", io_out_bits, e);
                end else begin
                    $display("out word %h", io_out_bits);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_credits(input string name, input logic [CNT_W-1:0] exp);
        vectors++;
        if (io_credits !== exp) begin
            errors++;
            $display("FAIL %s: credits got %0d required %0d", name, io_credits, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; io_in_valid = 1'b0; io_in_bits = '0; io_credit_return = 1'b0;
        step();
        reset = 1'b0;
        chk_credits("reset_credits", 2);
        vectors++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", io_in_ready); end
        vectors++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", io_out_valid); end
        vectors++;
        if (io_out_bits !== 8'h00) begin errors++; $display("FAIL reset_out_bits: got %h required 00", io_out_bits); end
        vectors++;
        if (io_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", io_err); end
        $display("reset applied");
    endtask

    task automatic test_back_to_back();
        io_in_valid = 1'b1; io_in_bits = 8'hA5; exp_q.push_back(8'hA5);
        step();
        chk_credits("b2b_credits1", 1);
        io_in_bits = 8'h3C; exp_q.push_back(8'h3C);
        step();
        chk_credits("b2b_credits0", 0);
        vectors++;
        if (io_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b required 0", io_in_ready); end
        io_in_valid = 1'b0;
        step();
    endtask

    task automatic test_return_at_zero();
        io_in_valid = 1'b1; io_in_bits = 8'h77;
        step();
        step();
        chk_credits("stall_credits", 0);
        vectors++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL stall_out_valid: got %b required 0", io_out_valid); end
        io_credit_return = 1'b1;
`ifdef CREDIT_SENDER_RETURN_BYPASS_EN
        exp_q.push_back(8'h77);
        step();
        io_credit_return = 1'b0; io_in_valid = 1'b0;
        chk_credits("ret0_bypass_credits", 0);
`else
        step();
        chk_credits("ret0_credits", 1);
        vectors++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL ret0_ready: got %b required 1", io_in_ready); end
        io_credit_return = 1'b0;
        exp_q.push_back(8'h77);
        step();
        io_in_valid = 1'b0;
        chk_credits("ret0_after_fire", 0);
`endif
        step();
    endtask

    task automatic test_fire_and_return();
        io_credit_return = 1'b1;
        step();
        io_credit_return = 1'b0;
        chk_credits("far_prep", 1);
        io_in_valid = 1'b1; io_in_bits = 8'h11; io_credit_return = 1'b1; exp_q.push_back(8'h11);
        step();
        io_in_valid = 1'b0; io_credit_return = 1'b0;
        chk_credits("far_credits", 1);
        step();
    endtask

    task automatic test_overflow();
        io_credit_return = 1'b1;
        step();
        io_credit_return = 1'b0;
        chk_credits("ovf_full", 2);
        vectors++;
        if (io_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b required 0", io_err); end
        io_credit_return = 1'b1;
        step();
        io_credit_return = 1'b0;
        chk_credits("ovf_saturate", 2);
        vectors++;
        if (io_err !== 1'b1) begin errors++; $display("FAIL ovf_err_set: got %b required 1", io_err); end
        io_in_valid = 1'b1; io_in_bits = 8'hC3; exp_q.push_back(8'hC3);
        step();
        io_in_valid = 1'b0; io_credit_return = 1'b1;
        step();
        io_credit_return = 1'b0;
        chk_credits("ovf_traffic", 2);
        vectors++;
        if (io_err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b required 1", io_err); end
        io_in_valid = 1'b1; io_in_bits = 8'h99; reset = 1'b1;
        step();
        reset = 1'b0; io_in_valid = 1'b0;
        chk_credits("ovf_reset_credits", 2);
        vectors++;
        if (io_err !== 1'b0) begin errors++; $display("FAIL ovf_reset_err: got %b required 0", io_err); end
        vectors++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_reset_out_valid: got %b required 0", io_out_valid); end
    endtask

    task automatic test_bypass_case();
        io_in_valid = 1'b1; io_in_bits = 8'h21; exp_q.push_back(8'h21);
        step();
        io_in_bits = 8'h42; exp_q.push_back(8'h42);
        step();
        chk_credits("byp_drained", 0);
        io_in_bits = 8'h5A; io_credit_return = 1'b1;
`ifdef CREDIT_SENDER_RETURN_BYPASS_EN
        exp_q.push_back(8'h5A);
        step();
        chk_credits("byp_credits", 0);
        vectors++;
        if (io_out_valid !== 1'b1) begin errors++; $display("FAIL byp_out_valid: got %b required 1", io_out_valid); end
`else
        step();
        chk_credits("byp_credits", 1);
        vectors++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL byp_out_valid: got %b required 0", io_out_valid); end
`endif
        io_in_valid = 1'b0; io_credit_return = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_return_at_zero();
        test_fire_and_return();
        test_overflow();
        test_bypass_case();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words outstanding required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
